// File: rtl/pipeline_ctrl.sv
// Hazard/stall sequencer for the 5-stage pipeline: per-stage write enables and bubble clears.
// Optional performance counters are built only when PIPE_PERF_EN is defined.
module pipeline_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8,
  parameter int PERF_W      = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [4:0]        ex_rd,
  input  logic              ex_memread,
  input  logic              ex_br_taken,
  input  logic              ex_mc_start,
  input  logic              mc_done,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_wen,
  output logic              if_id_wen,
  output logic              id_ex_wen,
  output logic              ex_mem_wen,
  output logic              mem_wb_wen,
  output logic              if_id_clear,
  output logic              id_ex_clear,
  output logic              ex_mem_clear,
  output logic              mem_wb_clear,
  output logic              mem_err,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] flush_count
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] MC_WAIT  = 2'd2;

  typedef enum logic [2:0] {
    O_PASS,  // everything advances
    O_MEM,   // MEM frozen, bubble into MEM_WB
    O_MC,    // EX frozen, bubble into EX_MEM
    O_BR,    // redirect: squash IF_ID and ID_EX
    O_LU     // load-use: hold PC/IF_ID, bubble into ID_EX
  } out_mode_e;

  logic [1:0]      state, state_nxt;
  logic            mc_ret, mc_ret_nxt;
  logic [TO_W-1:0] to_cnt, to_cnt_nxt;
  logic            mem_err_nxt;
  out_mode_e       mode;
  logic            load_use, mem_stall, mc_stall;

  assign load_use  = ex_memread && (ex_rd != 5'd0) &&
                     ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
  assign mem_stall = mem_req && !mem_ready;
  assign mc_stall  = ex_mc_start && !mc_done;

  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one unassigned (no latches).
    mode        = O_PASS;
    state_nxt   = state;
    mc_ret_nxt  = mc_ret;
    to_cnt_nxt  = to_cnt;
    mem_err_nxt = 1'b0;
    case (state)
      RUN: begin
        if (mem_stall) begin
          mode       = O_MEM;
          state_nxt  = MEM_WAIT;
          mc_ret_nxt = 1'b0;
          to_cnt_nxt = TO_W'(1);
        end else if (mc_stall) begin
          mode      = O_MC;
          state_nxt = MC_WAIT;
        end else if (ex_br_taken) begin
          mode = O_BR;
        end else if (load_use) begin
          mode = O_LU;
        end
      end
      MEM_WAIT: begin
        if (mem_ready || (to_cnt == TO_W'(MEM_TIMEOUT))) begin
          // Leaving a wait nested inside a multi-cycle op keeps EX frozen.
          mode        = mc_ret ? O_MC : O_PASS;
          state_nxt   = mc_ret ? MC_WAIT : RUN;
          mc_ret_nxt  = 1'b0;
          to_cnt_nxt  = '0;
          mem_err_nxt = !mem_ready;
        end else begin
          mode       = O_MEM;
          to_cnt_nxt = to_cnt + TO_W'(1);
        end
      end
      MC_WAIT: begin
        if (mem_stall) begin
          mode       = O_MEM;
          state_nxt  = MEM_WAIT;
          mc_ret_nxt = 1'b1;
          to_cnt_nxt = TO_W'(1);
        end else if (mc_done) begin
          state_nxt = RUN;
        end else begin
          mode = O_MC;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // Strobes are gated by rstn so the pipeline is fully quiet while reset is held.
  always_comb begin
    pc_wen       = rstn && ((mode == O_PASS) || (mode == O_BR));
    if_id_wen    = rstn && ((mode == O_PASS) || (mode == O_BR));
    id_ex_wen    = rstn && (mode != O_MEM) && (mode != O_MC);
    ex_mem_wen   = rstn && (mode != O_MEM);
    mem_wb_wen   = rstn;
    if_id_clear  = rstn && (mode == O_BR);
    id_ex_clear  = rstn && ((mode == O_BR) || (mode == O_LU));
    ex_mem_clear = rstn && (mode == O_MC);
    mem_wb_clear = rstn && (mode == O_MEM);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= RUN;
      mc_ret  <= 1'b0;
      to_cnt  <= '0;
      mem_err <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state   <= state_nxt;
      mc_ret  <= mc_ret_nxt;
      to_cnt  <= to_cnt_nxt;
      mem_err <= mem_err_nxt;
    end
  end

`ifdef PIPE_PERF_EN
  logic flush_evt;
  assign flush_evt = (mode == O_BR);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_wen && (stall_cycles != '1)) stall_cycles <= stall_cycles + PERF_W'(1);
      if (flush_evt && (flush_count != '1)) flush_count <= flush_count + PERF_W'(1);
    end
  end
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule
